shift_rows_pipe: RTL and testbench

- Parametrised, pipelined ShiftRows/InvShiftRows unit for the AES datapath, generalised to Rijndael block widths NB = 4, 6 or 8 columns.
- Direction is chosen per transaction. Valid/ready handshake on both sides; full throughput of one block per cycle.
- Sits between SubBytes/InvSubBytes and MixColumns in the round pipeline, replacing purely combinational row-rotation logic where a register boundary is needed.

---
 rtl/shift_rows_pipe.sv | 149 ++++++++++++++
 tb/tb_shift_rows_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows for Rijndael states of NB = 4, 6 or 8 columns.
// Optional feature: define SHIFT_ROWS_PIPE_BYPASS_EN to add a per-block bypass tag.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [32*NB-1:0] in_data_i,
  input  logic            in_inv_i,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  input  logic            in_bypass_i,
  output logic            out_bypass_o,
`endif
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [32*NB-1:0] out_data_o,
  output logic            out_inv_o
);

  localparam int W  = 32 * NB;
  localparam int RW = 8 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Rows 2 and 3 shift one further for the 8-column block size.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [W-1:0] perm;
  logic [W-1:0] s1_din;
  logic         bypass_in;

  always_comb begin
    perm = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (in_inv_i)
          perm[r*RW + 8*c +: 8] = in_data_i[r*RW + 8*((c + NB - row_shift(r)) % NB) +: 8];
        else
          perm[r*RW + 8*c +: 8] = in_data_i[r*RW + 8*((c + row_shift(r)) % NB) +: 8];
      end
    end
  end

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  assign bypass_in = in_bypass_i;
`else
  assign bypass_in = 1'b0;
`endif

  assign s1_din = bypass_in ? in_data_i : perm;

  logic         s1_valid;
  logic [W-1:0] s1_data;
  logic         s1_inv;
  logic         s1_ready;
  logic         down_ready;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  logic         s1_byp;
`endif

  assign s1_ready   = !s1_valid || down_ready;
  assign in_ready_o = s1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
      s1_byp   <= 1'b0;
`endif
    end else if (s1_ready) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_data <= s1_din;
        s1_inv  <= in_inv_i;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        s1_byp  <= bypass_in;
`endif
      end
    end
  end

  if (STAGES == 1) begin : g_one
    assign down_ready  = out_ready_i;
    assign out_valid_o = s1_valid;
    assign out_data_o  = s1_data;
    assign out_inv_o   = s1_inv;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign out_bypass_o = s1_byp;
`endif
  end else if (STAGES == 2) begin : g_two
    logic         s2_valid;
    logic [W-1:0] s2_data;
    logic         s2_inv;
    logic         s2_ready;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    logic         s2_byp;
`endif

    assign s2_ready   = !s2_valid || out_ready_i;
    assign down_ready = s2_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_inv   <= 1'b0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        s2_byp   <= 1'b0;
`endif
      end else if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_inv  <= s1_inv;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
          s2_byp  <= s1_byp;
`endif
        end
      end
    end

    assign out_valid_o = s2_valid;
    assign out_data_o  = s2_data;
    assign out_inv_o   = s2_inv;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign out_bypass_o = s2_byp;
`endif
  end else begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1 or 2");
    assign down_ready  = out_ready_i;
    assign out_valid_o = 1'b0;
    assign out_data_o  = '0;
    assign out_inv_o   = 1'b0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign out_bypass_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4/STAGES=1, NB=8/STAGES=1 and NB=4/STAGES=2 instances.
// Bypass checks are compiled in when SHIFT_ROWS_PIPE_BYPASS_EN is defined.
module tb_shift_rows_pipe;

  localparam logic [127:0] V = 128'h33323130_23222120_13121110_03020100;
  localparam logic [127:0] F = 128'h32313033_21202322_10131211_03020100;
  localparam logic [127:0] I = 128'h30333231_21202322_12111013_03020100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic a_iv, a_ir, a_inv, a_ov, a_or, a_oinv;
  logic [127:0] a_id, a_od;
  logic b_iv, b_ir, b_inv, b_ov, b_or, b_oinv;
  logic [255:0] b_id, b_od;
  logic c_iv, c_ir, c_inv, c_ov, c_or, c_oinv;
  logic [127:0] c_id, c_od;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  logic a_byp, a_obyp, b_byp, b_obyp, c_byp, c_obyp;
`endif

  shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
    .in_inv_i(a_inv),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass_i(a_byp), .out_bypass_o(a_obyp),
`endif
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .out_inv_o(a_oinv));

  shift_rows_pipe #(.NB(8), .STAGES(1)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
    .in_inv_i(b_inv),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass_i(b_byp), .out_bypass_o(b_obyp),
`endif
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .out_inv_o(b_oinv));

  shift_rows_pipe #(.NB(4), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_data_i(c_id),
    .in_inv_i(c_inv),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    .in_bypass_i(c_byp), .out_bypass_o(c_obyp),
`endif
    .out_valid_o(c_ov), .out_ready_i(c_or), .out_data_o(c_od), .out_inv_o(c_oinv));

  // Scatter-form reference: each input byte is moved to its destination column.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    int s, dst;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        dst = inv ? (c + s) % nb : (c - s + nb) % nb;
        o[r*8*nb + 8*dst +: 8] = d[r*8*nb + 8*c +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] blk(input int k);
    logic [7:0] m;
    m = 8'(k * 17);
    return V ^ {16{m}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b want 0", a_ov); end
    n_checks++; if (a_od !== 128'h0) begin n_fail++; $display("FAIL reset_a_data: got %h want 0", a_od); end
    n_checks++; if (a_oinv !== 1'b0) begin n_fail++; $display("FAIL reset_a_inv: got %b want 0", a_oinv); end
    n_checks++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %b want 1", a_ir); end
    n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL reset_c_valid: got %b want 0", c_ov); end
    n_checks++; if (c_od !== 128'h0) begin n_fail++; $display("FAIL reset_c_data: got %h want 0", c_od); end
    n_checks++; if (c_ir !== 1'b1) begin n_fail++; $display("FAIL reset_c_ready: got %b want 1", c_ir); end
    n_checks++; if (b_od !== 256'h0) begin n_fail++; $display("FAIL reset_b_data: got %h want 0", b_od); end
  endtask

  task automatic test_forward_nb4();
    a_id = V; a_inv = 1'b0; a_iv = 1'b1; a_or = 1'b1;
    step();
    a_iv = 1'b0; a_id = '0;
    n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL fwd4_valid: got %b want 1", a_ov); end
    n_checks++; if (a_od !== F) begin n_fail++; $display("FAIL fwd4_data: got %h want %h", a_od, F); end
    n_checks++; if (a_oinv !== 1'b0) begin n_fail++; $display("FAIL fwd4_inv: got %b want 0", a_oinv); end
    step();
    n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL fwd4_drain: got %b want 0", a_ov); end
  endtask

  task automatic test_inverse_nb4();
    a_id = V; a_inv = 1'b1; a_iv = 1'b1; a_or = 1'b1;
    step();
    n_checks++; if (a_od !== I) begin n_fail++; $display("FAIL inv4_data: got %h want %h", a_od, I); end
    n_checks++; if (a_oinv !== 1'b1) begin n_fail++; $display("FAIL inv4_tag: got %b want 1", a_oinv); end
    a_id = I; a_inv = 1'b0;
    step();
    a_iv = 1'b0;
    n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL roundtrip4_valid: got %b want 1", a_ov); end
    n_checks++; if (a_od !== V) begin n_fail++; $display("FAIL roundtrip4_data: got %h want %h", a_od, V); end
    step();
  endtask

  task automatic test_nb8();
    logic [255:0] d8, fwd;
    logic [7:0] want;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        d8[r*64 + 8*c +: 8] = 8'(r * 16 + c);
    b_id = d8; b_inv = 1'b0; b_iv = 1'b1; b_or = 1'b1;
    step();
    b_iv = 1'b0;
    fwd = b_od;
    n_checks++; if (b_ov !== 1'b1) begin n_fail++; $display("FAIL fwd8_valid: got %b want 1", b_ov); end
    for (int c = 0; c < 8; c++) begin
      want = 8'(16 + (c + 1) % 8);
      n_checks++; if (fwd[64 + 8*c +: 8] !== want) begin n_fail++; $display("FAIL fwd8_row1_c%0d: got %h want %h", c, fwd[64 + 8*c +: 8], want); end
      want = 8'(32 + (c + 3) % 8);
      n_checks++; if (fwd[128 + 8*c +: 8] !== want) begin n_fail++; $display("FAIL fwd8_row2_c%0d: got %h want %h", c, fwd[128 + 8*c +: 8], want); end
      want = 8'(48 + (c + 4) % 8);
      n_checks++; if (fwd[192 + 8*c +: 8] !== want) begin n_fail++; $display("FAIL fwd8_row3_c%0d: got %h want %h", c, fwd[192 + 8*c +: 8], want); end
    end
    n_checks++; if (fwd[63:0] !== d8[63:0]) begin n_fail++; $display("FAIL fwd8_row0: got %h want %h", fwd[63:0], d8[63:0]); end
    b_id = fwd; b_inv = 1'b1; b_iv = 1'b1;
    step();
    b_iv = 1'b0;
    n_checks++; if (b_od !== d8) begin n_fail++; $display("FAIL inv8_restore: got %h want %h", b_od, d8); end
    n_checks++; if (b_oinv !== 1'b1) begin n_fail++; $display("FAIL inv8_tag: got %b want 1", b_oinv); end
    step();
  endtask

  task automatic test_latency_s2();
    c_id = V; c_inv = 1'b0; c_iv = 1'b1; c_or = 1'b1;
    step();
    c_iv = 1'b0;
    n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL lat2_early: got %b want 0", c_ov); end
    step();
    n_checks++; if (c_ov !== 1'b1) begin n_fail++; $display("FAIL lat2_valid: got %b want 1", c_ov); end
    n_checks++; if (c_od !== F) begin n_fail++; $display("FAIL lat2_data: got %h want %h", c_od, F); end
    step();
    n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL lat2_drain: got %b want 0", c_ov); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_d [6];
    logic         exp_i [6];
    int si, ri;
    logic do_in, do_out, prev_stall, prev_i;
    logic [127:0] prev_d;
    for (int k = 0; k < 6; k++) begin
      exp_i[k] = k[0];
      exp_d[k] = ref_shift({128'h0, blk(k)}, 4, k[0]) [127:0];
    end
    si = 0; ri = 0; prev_stall = 1'b0; prev_d = '0; prev_i = 1'b0;
    for (int cyc = 0; cyc < 40 && ri < 6; cyc++) begin
      c_or  = !(cyc >= 3 && cyc <= 5);
      c_iv  = (si < 6);
      c_id  = blk(si);
      c_inv = si[0];
      #1;
      if (prev_stall) begin
        n_checks++; if (c_ov !== 1'b1 || c_od !== prev_d || c_oinv !== prev_i) begin
          n_fail++; $display("FAIL b2b_stall_stable cyc%0d: got v=%b d=%h t=%b want v=1 d=%h t=%b", cyc, c_ov, c_od, c_oinv, prev_d, prev_i);
        end
      end
      if (c_or) begin
        n_checks++; if (c_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_full_rate cyc%0d: got %b want 1", cyc, c_ir); end
      end else begin
        n_checks++; if (c_ir !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_stalled cyc%0d: got %b want 0", cyc, c_ir); end
      end
      do_in  = c_iv && c_ir;
      do_out = c_ov && c_or;
      if (do_out) begin
        if (ri < 6) begin
          n_checks++; if (c_od !== exp_d[ri] || c_oinv !== exp_i[ri]) begin
            n_fail++; $display("FAIL b2b_block%0d: got d=%h t=%b want d=%h t=%b", ri, c_od, c_oinv, exp_d[ri], exp_i[ri]);
          end
        end
        ri++;
      end
      prev_stall = c_ov && !c_or;
      prev_d = c_od;
      prev_i = c_oinv;
      @(posedge clk);
      #1;
      if (do_in) si++;
    end
    c_iv = 1'b0;
    n_checks++; if (ri != 6) begin n_fail++; $display("FAIL b2b_count: got %0d blocks want 6", ri); end
    #1;
    n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra: got valid %b want 0", c_ov); end
  endtask

  task automatic test_reset_mid();
    c_or = 1'b0; c_iv = 1'b1; c_inv = 1'b0;
    c_id = blk(1);
    step();
    c_id = blk(2);
    step();
    c_iv = 1'b0;
    n_checks++; if (c_ov !== 1'b1) begin n_fail++; $display("FAIL rstmid_loaded: got %b want 1", c_ov); end
    rst = 1'b1; c_iv = 1'b1; c_id = blk(3); c_or = 1'b1;
    step();
    rst = 1'b0; c_iv = 1'b0;
    n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", c_ov); end
    n_checks++; if (c_od !== 128'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", c_od); end
    n_checks++; if (c_oinv !== 1'b0) begin n_fail++; $display("FAIL rstmid_inv: got %b want 0", c_oinv); end
    n_checks++; if (c_ir !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", c_ir); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost%0d: got %b want 0", k, c_ov); end
    end
  endtask

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
  task automatic test_bypass();
    a_id = V; a_inv = 1'b0; a_byp = 1'b1; a_iv = 1'b1; a_or = 1'b1;
    step();
    a_iv = 1'b0; a_byp = 1'b0;
    n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %b want 1", a_ov); end
    n_checks++; if (a_od !== V) begin n_fail++; $display("FAIL byp_data: got %h want %h", a_od, V); end
    n_checks++; if (a_obyp !== 1'b1) begin n_fail++; $display("FAIL byp_tag: got %b want 1", a_obyp); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_inv = 1'b0; a_or = 1'b1; a_id = '0;
    b_iv = 1'b0; b_inv = 1'b0; b_or = 1'b1; b_id = '0;
    c_iv = 1'b0; c_inv = 1'b0; c_or = 1'b1; c_id = '0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    a_byp = 1'b0; b_byp = 1'b0; c_byp = 1'b0;
`endif
    test_reset();
    test_forward_nb4();
    test_inverse_nb4();
    test_nb8();
    test_latency_s2();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
